// File: rtl/exec_issue_ctrl_pkg.sv
// Shared types and constants for the execute-stage issue interlock.
// Holds the in-flight slot record and the register/flag widths.
package exec_issue_ctrl_pkg;

    localparam int NREG   = 32;
    localparam int REG_W  = 5;
    localparam int FLAG_W = 4;

    localparam logic [FLAG_W-1:0] FLAGS_ALL = 4'hF;

    typedef struct packed {
        logic            v;
        logic [NREG-1:0] wmask;
        logic            fw;
    } slot_t;

endpackage

// File: rtl/exec_slot_match.sv
// Builds the one-hot destination mask of the issuing instruction.
// Two equal enabled destinations collapse into a single bit.
module exec_slot_match
    import exec_issue_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_rd1,
    input  logic [REG_W-1:0] i_rd2,
    input  logic             i_rd1_en,
    input  logic             i_rd2_en,
    output logic [NREG-1:0]  o_wmask
);

    always_comb begin
        o_wmask = '0;
        if (i_rd1_en) o_wmask[i_rd1] = 1'b1;
        if (i_rd2_en) o_wmask[i_rd2] = 1'b1;
    end

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issue interlock between decode and execute: a shifting scoreboard of
// in-flight destinations and flag writes that stalls dependent instructions.
module exec_issue_ctrl
    import exec_issue_ctrl_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               d_valid,
    output logic               d_ready,
    input  logic [REG_W-1:0]   d_rs1,
    input  logic [REG_W-1:0]   d_rs2,
    input  logic               d_rs1_en,
    input  logic               d_rs2_en,
    input  logic [REG_W-1:0]   d_rd1,
    input  logic [REG_W-1:0]   d_rd2,
    input  logic               d_rd1_en,
    input  logic               d_rd2_en,
    input  logic [FLAG_W-1:0]  d_write_flags,
    input  logic               d_is_cond,
    input  logic               flush,
    input  logic               x_cancel,
    output logic               x_issue,
    output logic [NREG-1:0]    hz_busy,
    output logic               flags_busy,
    output logic [STALL_W-1:0] stall_cnt
);

    slot_t               r_slots [DEPTH];
    logic [STALL_W-1:0]  r_stall_cnt;

    logic [NREG-1:0]     w_wmask;
    slot_t               w_entry;
    slot_t               w_moved;
    logic [NREG-1:0]     w_hz_busy;
    logic                w_flags_busy;
    logic                w_reg_hazard;
    logic                w_needs_flags;
    logic                w_ready;
    logic                w_issue;

    exec_slot_match u_match (
        .i_rd1    (d_rd1),
        .i_rd2    (d_rd2),
        .i_rd1_en (d_rd1_en),
        .i_rd2_en (d_rd2_en),
        .o_wmask  (w_wmask)
    );

    always_comb begin
        w_entry       = '0;
        w_entry.v     = 1'b1;
        w_entry.wmask = w_wmask;
        w_entry.fw    = (d_write_flags != '0);
    end

    // A cancelled conditional keeps its slot but no longer blocks anyone.
    always_comb begin
        w_moved = r_slots[0];
        if (x_cancel) begin
            w_moved.wmask = '0;
            w_moved.fw    = 1'b0;
        end
    end

    always_comb begin
        w_hz_busy    = '0;
        w_flags_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_slots[i].v) begin
                w_hz_busy    = w_hz_busy | r_slots[i].wmask;
                w_flags_busy = w_flags_busy | r_slots[i].fw;
            end
        end
    end

    // Partial flag writes merge the old NZCV value, so they read flags too.
    always_comb begin
        w_reg_hazard  = (d_rs1_en & w_hz_busy[d_rs1]) | (d_rs2_en & w_hz_busy[d_rs2]);
        w_needs_flags = d_is_cond | ((d_write_flags != '0) & (d_write_flags != FLAGS_ALL));
        w_ready       = rst & ~flush & ~w_reg_hazard & ~(w_needs_flags & w_flags_busy);
        w_issue       = d_valid & w_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
        end else begin
            r_slots[0] <= w_issue ? w_entry : '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_slots[i] <= (i == 1) ? w_moved : r_slots[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (d_valid && !flush && !w_ready && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign d_ready    = w_ready;
    assign x_issue    = w_issue;
    assign hz_busy    = w_hz_busy;
    assign flags_busy = w_flags_busy;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Directed bench for exec_issue_ctrl: RAW stalls, cancel, flag hazards,
// flush, counter saturation (on a narrow-counter twin) and mid-flight reset.
module tb_exec_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        d_valid;
    logic [4:0]  d_rs1, d_rs2, d_rd1, d_rd2;
    logic        d_rs1_en, d_rs2_en, d_rd1_en, d_rd2_en;
    logic [3:0]  d_write_flags;
    logic        d_is_cond;
    logic        flush;
    logic        x_cancel;

    logic        d_ready, x_issue, flags_busy;
    logic [31:0] hz_busy;
    logic [15:0] stall_cnt;

    logic        n_ready, n_issue, n_flags_busy;
    logic [31:0] n_hz_busy;
    logic [3:0]  n_stall_cnt;

    int checks = 0;
    int fails  = 0;

    exec_issue_ctrl #(.DEPTH(3), .STALL_W(16)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_ready(d_ready),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs1_en(d_rs1_en), .d_rs2_en(d_rs2_en),
        .d_rd1(d_rd1), .d_rd2(d_rd2), .d_rd1_en(d_rd1_en), .d_rd2_en(d_rd2_en),
        .d_write_flags(d_write_flags), .d_is_cond(d_is_cond), .flush(flush),
        .x_cancel(x_cancel), .x_issue(x_issue), .hz_busy(hz_busy),
        .flags_busy(flags_busy), .stall_cnt(stall_cnt)
    );

    exec_issue_ctrl #(.DEPTH(3), .STALL_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_ready(n_ready),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs1_en(d_rs1_en), .d_rs2_en(d_rs2_en),
        .d_rd1(d_rd1), .d_rd2(d_rd2), .d_rd1_en(d_rd1_en), .d_rd2_en(d_rd2_en),
        .d_write_flags(d_write_flags), .d_is_cond(d_is_cond), .flush(flush),
        .x_cancel(x_cancel), .x_issue(n_issue), .hz_busy(n_hz_busy),
        .flags_busy(n_flags_busy), .stall_cnt(n_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_rd1 = 0; d_rd2 = 0;
        d_rs1_en = 0; d_rs2_en = 0; d_rd1_en = 0; d_rd2_en = 0;
        d_write_flags = 4'h0; d_is_cond = 0; flush = 0; x_cancel = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse away from the clock edge, then realign.
    task automatic do_reset();
        idle();
        @(negedge clk);
        rst = 0;
        #2;
        rst = 1;
        next_cycle();
    endtask

    task automatic test_reset();
        idle();
        d_valid = 1;
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (d_ready !== 1'b0 || x_issue !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_ready: d_ready=%b x_issue=%b want 0 0", d_ready, x_issue);
        end
        checks++;
        if (hz_busy !== 32'h0 || flags_busy !== 1'b0 || stall_cnt !== 16'h0) begin
            fails++; $display("[TB] FAIL reset_state: hz=%h fb=%b cnt=%0d want 0 0 0", hz_busy, flags_busy, stall_cnt);
        end
        rst = 1;
        #1;
        checks++;
        if (d_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL post_reset_ready: got %b want 1", d_ready);
        end
        idle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        d_valid = 1; d_rd1 = 5'd3; d_rd1_en = 1;
        @(negedge clk);
        checks++;
        if (x_issue !== 1'b1) begin
            fails++; $display("[TB] FAIL raw_producer_issue: got %b want 1", x_issue);
        end
        next_cycle();
        idle();
        d_valid = 1; d_rs1 = 5'd3; d_rs1_en = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (d_ready !== (c == 4)) begin
                fails++; $display("[TB] FAIL raw_ready_c%0d: got %b want %b", c, d_ready, (c == 4));
            end
            if (c == 1) begin
                checks++;
                if (hz_busy !== 32'h0000_0008) begin
                    fails++; $display("[TB] FAIL raw_hz_busy: got %h want 00000008", hz_busy);
                end
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd3) begin
            fails++; $display("[TB] FAIL raw_stall_cnt: got %0d want 3", stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_cancel();
        do_reset();
        d_valid = 1; d_rd1 = 5'd3; d_rd1_en = 1;
        next_cycle();
        idle();
        d_valid = 1; d_rs1 = 5'd3; d_rs1_en = 1; x_cancel = 1;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL cancel_c1_ready: got %b want 0", d_ready);
        end
        next_cycle();
        x_cancel = 0;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b1 || hz_busy[3] !== 1'b0) begin
            fails++; $display("[TB] FAIL cancel_c2: ready=%b hz3=%b want 1 0", d_ready, hz_busy[3]);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd1) begin
            fails++; $display("[TB] FAIL cancel_stall_cnt: got %0d want 1", stall_cnt);
        end
        next_cycle();
    endtask

    // Producer writes all flags; follower type picks the expected stall.
    task automatic flag_case(input logic [3:0] fwr, input logic cond, input int exp_stall, input string nm);
        do_reset();
        d_valid = 1; d_write_flags = 4'hF;
        next_cycle();
        idle();
        d_valid = 1; d_write_flags = fwr; d_is_cond = cond;
        for (int c = 1; c <= exp_stall + 1; c++) begin
            @(negedge clk);
            checks++;
            if (d_ready !== (c == exp_stall + 1)) begin
                fails++; $display("[TB] FAIL %s_ready_c%0d: got %b want %b", nm, c, d_ready, (c == exp_stall + 1));
            end
            if (c == 1) begin
                checks++;
                if (flags_busy !== 1'b1) begin
                    fails++; $display("[TB] FAIL %s_flags_busy: got %b want 1", nm, flags_busy);
                end
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            fails++; $display("[TB] FAIL %s_stall_cnt: got %0d want %0d", nm, stall_cnt, exp_stall);
        end
        next_cycle();
    endtask

    task automatic test_flags();
        flag_case(4'h0, 1'b1, 3, "flag_cond");
        flag_case(4'hF, 1'b0, 0, "flag_full");
        flag_case(4'b0100, 1'b0, 3, "flag_partial");
    endtask

    task automatic test_dual_dest();
        do_reset();
        d_valid = 1; d_rd1 = 5'd4; d_rd2 = 5'd9; d_rd1_en = 1; d_rd2_en = 1;
        next_cycle();
        idle();
        d_valid = 1; d_rd1 = 5'd0; d_rd2 = 5'd0; d_rd1_en = 1; d_rd2_en = 1;
        @(negedge clk);
        checks++;
        if (hz_busy !== 32'h0000_0210) begin
            fails++; $display("[TB] FAIL dual_hz: got %h want 00000210", hz_busy);
        end
        next_cycle();
        idle();
        d_valid = 1; d_rs2 = 5'd0; d_rs2_en = 1;
        @(negedge clk);
        checks++;
        if (hz_busy !== 32'h0000_0211 || d_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL r0_hazard: hz=%h ready=%b want 00000211 0", hz_busy, d_ready);
        end
        idle();
        next_cycle();
    endtask

    task automatic test_flush();
        do_reset();
        d_valid = 1; d_rd1 = 5'd3; d_rd1_en = 1;
        next_cycle();
        idle();
        d_valid = 1; d_rs1 = 5'd3; d_rs1_en = 1; flush = 1;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b0 || x_issue !== 1'b0) begin
            fails++; $display("[TB] FAIL flush_block: ready=%b issue=%b want 0 0", d_ready, x_issue);
        end
        next_cycle();
        flush = 0;
        for (int c = 2; c <= 4; c++) next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd2) begin
            fails++; $display("[TB] FAIL flush_stall_cnt: got %0d want 2", stall_cnt);
        end
        next_cycle();
    endtask

    // r7 <- f(r7) repeatedly: issue, stall x3 pattern, 21 stalls in 28 cycles.
    task automatic test_saturation();
        do_reset();
        d_valid = 1; d_rs1 = 5'd7; d_rs1_en = 1; d_rd1 = 5'd7; d_rd1_en = 1;
        for (int c = 0; c < 28; c++) next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (n_stall_cnt !== 4'd15) begin
            fails++; $display("[TB] FAIL sat_narrow: got %0d want 15", n_stall_cnt);
        end
        checks++;
        if (stall_cnt !== 16'd21) begin
            fails++; $display("[TB] FAIL sat_wide: got %0d want 21", stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            d_valid = 1; d_rd1 = 5'(k); d_rd1_en = 1;
            next_cycle();
        end
        idle();
        d_valid = 1; d_rs1 = 5'd3; d_rs1_en = 1;
        @(negedge clk);
        checks++;
        if (hz_busy !== 32'h0000_000E || d_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL mid_inflight: hz=%h ready=%b want 0000000e 0", hz_busy, d_ready);
        end
        next_cycle();
        rst = 0;
        #1;
        checks++;
        if (hz_busy !== 32'h0 || stall_cnt !== 16'h0 || flags_busy !== 1'b0 || x_issue !== 1'b0) begin
            fails++; $display("[TB] FAIL mid_reset: hz=%h cnt=%0d fb=%b issue=%b want 0 0 0 0", hz_busy, stall_cnt, flags_busy, x_issue);
        end
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if (d_ready !== 1'b1 || x_issue !== 1'b1) begin
            fails++; $display("[TB] FAIL mid_release_issue: ready=%b issue=%b want 1 1", d_ready, x_issue);
        end
        next_cycle();
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        #2;
        test_reset();
        test_back_to_back();
        test_cancel();
        test_flags();
        test_dual_dest();
        test_flush();
        test_saturation();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
